bicubic_win_sched: RTL and testbench

Scheduler that sequences the 4x4 line-buffer window feeding the bicubic interpolation core. It owns the fill, shift and flush timing of the window shift register. It handshakes upstream pixels in and window requests out, and counts the per-window interpolation responses. It also tracks the column and row position across one frame. It sits between the pixel source and the window buffer/bicubic core pair and replaces their free-running counters with an explicit state machine.

---
 rtl/bicubic_win_sched.sv | 155 +++++++++++++++
 tb/tb_bicubic_win_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_win_sched.sv
// rtl/bicubic_win_sched.sv - fill/shift/flush scheduler for the 4x4 bicubic window
module bicubic_win_sched #(
    parameter int WIDTH    = 960,
    parameter int HEIGHT   = 540,
    parameter int SUB_CNT  = 4,
    parameter int FILL_LEN = (WIDTH + 3) * 3 + 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       shift_en,
    output logic       pad,
    output logic       win_valid,
    input  logic       win_ready,
    input  logic       rsp_valid,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       busy,
    output logic       frame_done,
    output logic       rsp_err
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int FW   = $clog2(FILL_LEN + 1);
    localparam int IW   = $clog2(NPIX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_REQ,
        S_WAIT,
        S_SHIFT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [FW-1:0]   fill_cnt_q;
    logic [IW-1:0]   in_cnt_q;
    logic [3:0]      sub_cnt_q;
    logic [9:0]      col_q;
    logic [9:0]      row_q;
    logic            rsp_err_q;

    logic            shift_req;
    logic            exhausted;
    logic            accept;
    logic [9:0]      col_d;

    // Once every source pixel is in, the buffer keeps shifting with zero padding
    assign shift_req  = (state_q == S_FILL) || (state_q == S_SHIFT) || (state_q == S_FLUSH);
    assign exhausted  = (in_cnt_q == IW'(NPIX));
    assign in_ready   = shift_req & ~exhausted;
    assign shift_en   = shift_req & (in_valid | exhausted);
    assign pad        = shift_en & exhausted;
    assign accept     = in_valid & in_ready;
    assign col_d      = col_q + 10'd1;

    assign win_valid  = (state_q == S_REQ);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign col        = col_q;
    assign row        = row_q;
    assign rsp_err    = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fill_cnt_q <= '0;
            in_cnt_q   <= '0;
            sub_cnt_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                in_cnt_q <= in_cnt_q + 1'b1;
            end
            if (rsp_valid && (state_q != S_WAIT)) begin
                rsp_err_q <= 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_FILL;
                        fill_cnt_q <= '0;
                        in_cnt_q   <= '0;
                        sub_cnt_q  <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                        rsp_err_q  <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (shift_en) begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        if (fill_cnt_q == FW'(FILL_LEN - 1)) begin
                            state_q <= S_REQ;
                            col_q   <= '0;
                            row_q   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (win_ready) begin
                        sub_cnt_q <= '0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        sub_cnt_q <= sub_cnt_q + 4'd1;
                        if (sub_cnt_q == 4'(SUB_CNT - 1)) begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (shift_en) begin
                        col_q <= col_d;
                        if (col_d < 10'(WIDTH)) begin
                            state_q <= S_REQ;
                        end else if (row_q == 10'(HEIGHT - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                // Three padding columns move the window across the row boundary
                S_FLUSH: begin
                    if (shift_en) begin
                        if (col_q == 10'(WIDTH + 2)) begin
                            col_q   <= '0;
                            row_q   <= row_q + 10'd1;
                            state_q <= S_REQ;
                        end else begin
                            col_q <= col_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bicubic_win_sched.sv
// tb/tb_bicubic_win_sched.sv - directed bench for bicubic_win_sched on an 11x6 frame
module tb_bicubic_win_sched;

    localparam int W = 11;
    localparam int H = 6;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       win_ready = 1'b0;
    logic       rsp_valid = 1'b0;
    logic       in_ready, shift_en, pad, win_valid, busy, frame_done, rsp_err;
    logic [9:0] col, row;

    always #5 clk = ~clk;

    bicubic_win_sched #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .SUB_CNT (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .pad        (pad),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .rsp_valid  (rsp_valid),
        .col        (col),
        .row        (row),
        .busy       (busy),
        .frame_done (frame_done),
        .rsp_err    (rsp_err)
    );

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int s_in_ready, s_shift_en, s_pad, s_win_valid, s_busy, s_frame_done, s_rsp_err, s_col, s_row;
    int fill_sh, run_sh, pad_sh, acc, acc_at_pad, hs, rsps, fd;
    int flush_r0, flush_wv, wrap_pend, wrap_seen, wrap_col, wrap_row, wrap_wv;
    int seen_win, auto_rsp, rsp_left;

    task automatic clr_stats();
        fill_sh = 0; run_sh = 0; pad_sh = 0; acc = 0; acc_at_pad = -1;
        hs = 0; rsps = 0; fd = 0; seen_win = 0;
        flush_r0 = 0; flush_wv = 0; wrap_pend = 0; wrap_seen = 0;
        wrap_col = -1; wrap_row = -1; wrap_wv = -1;
        s_win_valid = 0; s_frame_done = 0;
    endtask

    // One clock: sample outputs on the falling edge, then let the core model drive the next cycle
    task automatic tick();
        @(negedge clk);
        s_in_ready   = int'(in_ready);
        s_shift_en   = int'(shift_en);
        s_pad        = int'(pad);
        s_win_valid  = int'(win_valid);
        s_busy       = int'(busy);
        s_frame_done = int'(frame_done);
        s_rsp_err    = int'(rsp_err);
        s_col        = int'(col);
        s_row        = int'(row);
        if (wrap_pend != 0) begin
            wrap_col = s_col; wrap_row = s_row; wrap_wv = s_win_valid;
            wrap_pend = 0; wrap_seen = 1;
        end
        if (shift_en) begin
            if (seen_win == 0) fill_sh++; else run_sh++;
            if (pad) begin
                if (pad_sh == 0) acc_at_pad = acc;
                pad_sh++;
            end
            if (seen_win != 0 && s_row == 0 && s_col >= W) begin
                flush_r0++;
                if (win_valid) flush_wv++;
                if (s_col == W + 2) wrap_pend = 1;
            end
        end
        if (in_valid && in_ready) acc++;
        if (win_valid) seen_win = 1;
        if (win_valid && win_ready) begin
            hs++;
            if (auto_rsp != 0) rsp_left = S;
        end
        if (rsp_valid) rsps++;
        if (frame_done) fd++;
        @(posedge clk);
        #1;
        if (auto_rsp != 0) begin
            rsp_valid = (rsp_left > 0);
            if (rsp_left > 0) rsp_left--;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int bad;
        auto_rsp = 0;
        rsp_left = 0;
        clr_stats();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_flags", int'({in_ready, shift_en, pad, frame_done, rsp_err}), 0);
        chk("rst_col_row", int'({col, row}), 0);
        rst_n = 1'b1;

        // Basic frame, exhaustion and row wrap
        clr_stats();
        auto_rsp = 1; in_valid = 1'b1; win_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("start_cycle_idle", s_busy, 0);
        tick();
        chk("fill_first_busy", s_busy, 1);
        chk("fill_first_shift", s_shift_en, 1);
        guard = 0;
        while (s_frame_done == 0 && guard < 2000) begin tick(); guard++; end
        chk("f1_done_seen", s_frame_done, 1);
        tick();
        chk("f1_fill_shifts", fill_sh, 47);
        chk("f1_handshakes", hs, 66);
        chk("f1_responses", rsps, 264);
        chk("f1_run_shifts", run_sh, 81);
        chk("f1_frame_done_cnt", fd, 1);
        chk("f1_rsp_err", s_rsp_err, 0);
        chk("f1_accepted", acc, 66);
        chk("f1_pad_shifts", pad_sh, 62);
        chk("f1_acc_at_first_pad", acc_at_pad, 66);
        chk("f1_final_col", s_col, W);
        chk("f1_final_row", s_row, H - 1);
        chk("f1_idle_after", s_busy, 0);
        chk("wrap_flush_shifts", flush_r0, 3);
        chk("wrap_flush_win_valid", flush_wv, 0);
        chk("wrap_seen", wrap_seen, 1);
        chk("wrap_col", wrap_col, 0);
        chk("wrap_row", wrap_row, 1);
        chk("wrap_win_valid", wrap_wv, 1);

        // Backpressure, stray response and ignored start
        clr_stats();
        auto_rsp = 0; win_ready = 1'b0; in_valid = 1'b1; rsp_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        guard = 0;
        while (s_win_valid == 0 && guard < 200) begin tick(); guard++; end
        chk("bp_req_reached", s_win_valid, 1);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            rsp_valid = (k == 1);
            tick();
            if (s_win_valid != 1 || s_shift_en != 0 || s_col != 0) bad++;
        end
        rsp_valid = 1'b0;
        chk("bp_req_hold", bad, 0);
        chk("stray_rsp_err", s_rsp_err, 1);
        win_ready = 1'b1;
        tick();
        chk("bp_req_release", s_win_valid, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("wait_no_req_shift", s_win_valid + s_shift_en, 0);
        chk("wait_busy", s_busy, 1);
        for (int k = 0; k < S; k++) begin
            rsp_valid = 1'b1;
            tick();
        end
        rsp_valid = 1'b0; in_valid = 1'b0; auto_rsp = 1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (s_shift_en != 0 || s_win_valid != 0 || s_busy != 1 || s_col != 0 || s_in_ready != 1) bad++;
        end
        chk("bp_shift_stall", bad, 0);
        in_valid = 1'b1;
        tick();
        chk("bp_shift_resume", s_shift_en, 1);
        chk("bp_shift_col_held", s_col, 0);
        tick();
        chk("bp_next_req", s_win_valid, 1);
        chk("bp_next_col", s_col, 1);
        chk("stray_rsp_err_held", s_rsp_err, 1);
        guard = 0;
        while (s_frame_done == 0 && guard < 2000) begin tick(); guard++; end
        chk("f2_done_seen", s_frame_done, 1);
        chk("f2_rsp_err_sticky", s_rsp_err, 1);
        tick();

        // Accepted start clears the error, then a mid-frame reset in WAIT
        clr_stats();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("start_clears_err", s_rsp_err, 0);
        guard = 0;
        while (!(s_row == 2 && s_win_valid == 1) && guard < 2000) begin tick(); guard++; end
        chk("mr_row2_req", s_row * 10 + s_win_valid, 21);
        tick();
        chk("mr_in_wait", s_busy * 2 + s_win_valid, 2);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", int'(busy), 0);
        chk("mr_win_valid", int'(win_valid), 0);
        chk("mr_flags", int'({in_ready, shift_en, pad, frame_done, rsp_err}), 0);
        chk("mr_col_row", int'({col, row}), 0);
        auto_rsp = 0; rsp_left = 0; rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_stats();
        auto_rsp = 1;
        start = 1'b1; tick(); start = 1'b0;
        guard = 0;
        while (s_win_valid == 0 && guard < 200) begin tick(); guard++; end
        chk("mr_refill_shifts", fill_sh, 47);
        chk("mr_refill_win", s_win_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
